apb_irq_ctrl: RTL and testbench

Parametrised APB interrupt controller that replaces the fixed event-unit/priority-encoder pairing in the MCU top. It collects N_IRQ peripheral interrupt sources (UART, GPIO, timers, ...) and synchronises each one. Each source is programmable as level or rising-edge, with pending/mask state per source. The block drives a registered irq/irq_id pair to the RISC-V core, and the core's acknowledge clears edge-mode pending bits.

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_sync_edge.sv | 32 +++
 rtl/apb_irq_ctrl.sv | 115 +++++++++++
 tb/tb_apb_irq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the APB interrupt controller: register word offsets
// (PADDR[4:2]) and interrupt ID sizing.
package irq_ctrl_pkg;

  localparam int IRQ_ID_WIDTH = 5;
  localparam int MAX_IRQ      = 32;

  localparam logic [2:0] REG_MASK     = 3'd0;
  localparam logic [2:0] REG_MODE     = 3'd1;
  localparam logic [2:0] REG_PEND     = 3'd2;
  localparam logic [2:0] REG_PEND_SET = 3'd3;
  localparam logic [2:0] REG_PEND_CLR = 3'd4;
  localparam logic [2:0] REG_ID       = 3'd5;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: SYNC_STAGES-deep synchroniser followed by an
// edge-history flop. s is the synchronised level, rise is high for the one
// cycle in which s is high and was low on the previous cycle.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   p;

  // Shift the raw source through the synchroniser and remember the last s.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
      p     <= 1'b0;
    end else begin
      chain[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      p <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~p;

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: per-source synchroniser, level/rising-edge
// pending logic, mask, highest-index-wins priority encoder and a registered
// irq/irq_id pair towards the core. The core's ack clears edge pending bits.
module apb_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_IRQ          = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [N_IRQ-1:0]          irq_src_i,
  output logic                      irq_o,
  output logic [IRQ_ID_WIDTH-1:0]   irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [IRQ_ID_WIDTH-1:0]   irq_ack_id_i,
  output logic                      event_o
);

  logic [2:0]              off;
  logic                    access, wr, rd;
  logic [N_IRQ-1:0]        wdata;
  logic [N_IRQ-1:0]        mask, mode, pend_q;
  logic [N_IRQ-1:0]        s, rise, pend, active;
  logic [N_IRQ-1:0]        ack_v, pset_v, pclr_v, set_v, clr_v;
  logic [IRQ_ID_WIDTH-1:0] hi_id;
  logic                    unused;

  assign off    = PADDR[4:2];
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign rd     = access & ~PWRITE;
  assign wdata  = PWDATA[N_IRQ-1:0];
  assign PREADY = 1'b1;
  assign unused = ^{PADDR, PWDATA};

  generate
    for (genvar i = 0; i < N_IRQ; i++) begin : g_src
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .src   (irq_src_i[i]),
        .s     (s[i]),
        .rise  (rise[i])
      );
    end
  endgenerate

  // Set/clear vectors for the edge pending flops; an ack ID outside the
  // implemented range matches no bit and so does nothing.
  always_comb begin
    ack_v = '0;
    for (int i = 0; i < N_IRQ; i++)
      ack_v[i] = irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(i));
    pset_v = (wr && off == REG_PEND_SET) ? wdata : '0;
    pclr_v = (wr && off == REG_PEND_CLR) ? wdata : '0;
    set_v  = (rise | pset_v) & mode;
    clr_v  = pclr_v | (ack_v & mode);
  end

  // Level sources report the live synchronised input, edge sources the flop.
  assign pend   = (pend_q & mode) | (s & ~mode);
  assign active = pend & mask;

  // Priority encoder: the last (highest) active index wins.
  always_comb begin
    hi_id = '0;
    for (int i = 0; i < N_IRQ; i++)
      if (active[i]) hi_id = IRQ_ID_WIDTH'(i);
  end

  // Register file, pending flops (set beats clear) and core-facing outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask     <= '0;
      mode     <= '0;
      pend_q   <= '0;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
      event_o  <= 1'b0;
    end else begin
      if (wr && off == REG_MASK) mask <= wdata;
      if (wr && off == REG_MODE) mode <= wdata;
      pend_q  <= (pend_q & ~clr_v) | set_v;
      irq_o   <= |active;
      if (|active) irq_id_o <= hi_id;
      event_o <= |(set_v & mask & ~pend_q);
    end
  end

  // Read mux, combinational in the access phase; top two offsets error.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = access && (off >= 3'd6);
    if (rd) begin
      case (off)
        REG_MASK: PRDATA[N_IRQ-1:0] = mask;
        REG_MODE: PRDATA[N_IRQ-1:0] = mode;
        REG_PEND: PRDATA[N_IRQ-1:0] = pend;
        REG_ID:   PRDATA = {irq_o, 26'b0, irq_id_o};
        default:  PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Bench for apb_irq_ctrl: directed scenarios plus a randomized run, checked
// against a cycle-level behavioural model of the controller's rules.
module tb_apb_irq_ctrl;

  localparam int S = 2;
  localparam int LVL_LAT  = S + 1;  // edges from driving a level source to irq_o
  localparam int EDGE_LAT = S + 2;  // edges from driving an edge source to irq_o

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic pwrite = 0, psel = 0, penable = 0, tgt5 = 0;
  logic [31:0] src = '0;
  logic [4:0]  src5 = '0;
  logic ack = 0;
  logic [4:0] ack_id = '0;
  logic psel_m, psel_5, ack_m, ack_5;
  logic [31:0] prdata_m, prdata_5;
  logic pready_m, pready_5, pslverr_m, pslverr_5;
  logic irq, evt, irq5, evt5;
  logic [4:0] irq_id, id5;

  assign psel_m = psel & ~tgt5;
  assign psel_5 = psel & tgt5;
  assign ack_m  = ack & ~tgt5;
  assign ack_5  = ack & tgt5;

  apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .N_IRQ(32), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_m), .PENABLE(penable), .PRDATA(prdata_m), .PREADY(pready_m),
    .PSLVERR(pslverr_m), .irq_src_i(src), .irq_o(irq), .irq_id_o(irq_id),
    .irq_ack_i(ack_m), .irq_ack_id_i(ack_id), .event_o(evt));

  apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .N_IRQ(5), .SYNC_STAGES(S)) dut5 (
    .clk_i(clk), .rst_i(rst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_5), .PENABLE(penable), .PRDATA(prdata_5), .PREADY(pready_5),
    .PSLVERR(pslverr_5), .irq_src_i(src5), .irq_o(irq5), .irq_id_o(id5),
    .irq_ack_i(ack_5), .irq_ack_id_i(ack_id), .event_o(evt5));

  int n_cmp = 0, n_err = 0;

  // ---------------- reference model (main 32-source instance) -------------
  // mq[k] = source vector sampled k+1 edges ago; s is the value S edges old.
  logic [31:0] mq [0:S];
  logic [31:0] m_mask, m_mode, m_flop;
  logic        m_irq, m_evt;
  logic [4:0]  m_id;

  function automatic logic f_wr(input logic [2:0] o);
    return psel_m && penable && pwrite && (paddr[4:2] == o);
  endfunction
  function automatic logic [31:0] f_s();    return mq[S-1]; endfunction
  function automatic logic [31:0] f_rise(); return mq[S-1] & ~mq[S]; endfunction
  function automatic logic [31:0] f_pend();
    return (m_flop & m_mode) | (f_s() & ~m_mode);
  endfunction
  function automatic logic [31:0] f_set();
    return (f_rise() | (f_wr(3'd3) ? pwdata : 32'h0)) & m_mode;
  endfunction
  function automatic logic [31:0] f_clr();
    logic [31:0] a;
    a = ack_m ? (32'h1 << ack_id) : 32'h0;
    return (f_wr(3'd4) ? pwdata : 32'h0) | (a & m_mode);
  endfunction
  function automatic logic [4:0] f_top(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (v[i]) r = 5'(i);
    return r;
  endfunction
  function automatic logic [31:0] m_read(input logic [2:0] o);
    case (o)
      3'd0: return m_mask;
      3'd1: return m_mode;
      3'd2: return f_pend();
      3'd5: return {m_irq, 26'b0, m_id};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mask <= '0; m_mode <= '0; m_flop <= '0;
      m_irq <= 1'b0; m_id <= '0; m_evt <= 1'b0;
      for (int k = 0; k <= S; k++) mq[k] <= '0;
    end else begin
      m_flop <= (m_flop & ~f_clr()) | f_set();
      m_evt  <= |(f_set() & m_mask & ~m_flop);
      m_irq  <= |(f_pend() & m_mask);
      if (|(f_pend() & m_mask)) m_id <= f_top(f_pend() & m_mask);
      if (f_wr(3'd0)) m_mask <= pwdata;
      if (f_wr(3'd1)) m_mode <= pwdata;
      mq[0] <= src;
      for (int k = 1; k <= S; k++) mq[k] <= mq[k-1];
    end
  end

  // ---------------- bus tasks (drive only, start/end at a negedge) --------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1; #1;
    d = tgt5 ? prdata_5 : prdata_m;
    e = tgt5 ? pslverr_5 : pslverr_m;
    @(negedge clk); psel = 0; penable = 0;
  endtask

  task automatic ack_pulse(input logic [4:0] id);
    ack = 1; ack_id = id;
    @(negedge clk); ack = 0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    logic [31:0] d; logic e;
    rst = 1; repeat (2) @(negedge clk);
    n_cmp++; if ({irq, irq_id, evt} !== 7'b0) begin n_err++; $display("FAIL reset_out: got irq=%0b id=%0d evt=%0b want 0", irq, irq_id, evt); end
    n_cmp++; if ({prdata_m, pslverr_m} !== 33'b0) begin n_err++; $display("FAIL reset_bus: got prdata=%h err=%0b want 0", prdata_m, pslverr_m); end
    rst = 0;
    for (int o = 0; o < 6; o++) begin
      apb_read(12'(o * 4), d, e);
      n_cmp++; if (d !== 32'h0 || e !== 1'b0 || pready_m !== 1'b1) begin n_err++; $display("FAIL reset_read off=%0h: got %h err=%0b rdy=%0b want 0/0/1", o * 4, d, e, pready_m); end
    end
    for (int o = 6; o < 8; o++) begin
      apb_read(12'(o * 4), d, e);
      n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL bad_off off=%0h: got %h err=%0b want 0 err=1", o * 4, d, e); end
    end
  endtask

  task automatic test_level();
    int lat;
    apb_write(12'h004, 32'h0);
    apb_write(12'h000, 32'h80);
    src[7] = 1'b1; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (irq && lat == 0) lat = c;
      n_cmp++; if ({irq, irq_id} !== {m_irq, m_id}) begin n_err++; $display("FAIL level_rise c=%0d: got %0b/%0d want %0b/%0d", c, irq, irq_id, m_irq, m_id); end
    end
    n_cmp++; if (lat != LVL_LAT || irq_id !== 5'd7) begin n_err++; $display("FAIL level_lat: got lat=%0d id=%0d want %0d/7", lat, irq_id, LVL_LAT); end
    src[7] = 1'b0; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!irq && lat == 0) lat = c;
    end
    n_cmp++; if (lat != LVL_LAT) begin n_err++; $display("FAIL level_fall: got lat=%0d want %0d", lat, LVL_LAT); end
    ack_pulse(5'd7); repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0 || m_flop !== 32'h0) begin n_err++; $display("FAIL level_ack: got irq=%0b want 0", irq); end
  endtask

  task automatic test_edge();
    logic [31:0] d; logic e; int ev, lat;
    apb_write(12'h004, 32'h0300_0000);
    apb_write(12'h000, 32'h0300_0000);
    src[24] = 1'b1; ev = 0; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) src[24] = 1'b0;
      if (evt) ev++;
      if (irq && lat == 0) lat = c;
      n_cmp++; if ({irq, irq_id, evt} !== {m_irq, m_id, m_evt}) begin n_err++; $display("FAIL edge_step c=%0d: got %0b/%0d/%0b want %0b/%0d/%0b", c, irq, irq_id, evt, m_irq, m_id, m_evt); end
    end
    n_cmp++; if (ev != 1 || lat != EDGE_LAT || irq_id !== 5'd24) begin n_err++; $display("FAIL edge_24: got ev=%0d lat=%0d id=%0d want 1/%0d/24", ev, lat, irq_id, EDGE_LAT); end
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h0100_0000) begin n_err++; $display("FAIL edge_pend: got %h want 01000000", d); end
    src[25] = 1'b1; @(negedge clk); src[25] = 1'b0; repeat (EDGE_LAT) @(negedge clk);
    n_cmp++; if (irq_id !== 5'd25 || irq !== 1'b1) begin n_err++; $display("FAIL edge_25: got id=%0d irq=%0b want 25/1", irq_id, irq); end
    ack_pulse(5'd25); @(negedge clk);
    n_cmp++; if (irq_id !== 5'd24 || irq !== 1'b1) begin n_err++; $display("FAIL ack_25: got id=%0d irq=%0b want 24/1", irq_id, irq); end
    ack_pulse(5'd24); @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ack_24: got irq=%0b want 0", irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d; logic e;
    apb_write(12'h004, 32'h8);
    apb_write(12'h010, 32'hFFFF_FFFF);
    src[3] = 1'b1;
    repeat (S - 1) @(negedge clk);
    apb_write(12'h010, 32'h8);   // clear lands on the edge the rise is seen
    apb_read(12'h008, d, e);
    n_cmp++; if (d[3] !== 1'b1 || d !== m_read(3'd2)) begin n_err++; $display("FAIL set_wins: got %h want bit3 set (%h)", d, m_read(3'd2)); end
    src[3] = 1'b0;
    apb_write(12'h010, 32'h8);
  endtask

  task automatic test_pend_set();
    logic [31:0] d; logic e;
    rst = 1; @(negedge clk); rst = 0;
    apb_write(12'h004, 32'h4);
    apb_write(12'h00C, 32'h4);
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h4 || irq !== 1'b0) begin n_err++; $display("FAIL pset: got pend=%h irq=%0b want 4/0", d, irq); end
    apb_write(12'h000, 32'h4);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pset_pre: got irq=%0b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1 || irq_id !== 5'd2) begin n_err++; $display("FAIL pset_irq: got %0b/%0d want 1/2", irq, irq_id); end
    rst = 1; @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq: got %0b want 0", irq); end
    rst = 0;
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_rst_pend: got %h want 0", d); end
  endtask

  task automatic test_n5();
    logic [31:0] d; logic e;
    tgt5 = 1;
    apb_write(12'h000, 32'hFFFF_FFFF);
    apb_read(12'h000, d, e);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL n5_mask: got %h want 1f", d); end
    apb_write(12'h004, 32'hFFFF_FFFF);
    apb_write(12'h00C, 32'hFFFF_FFFF);
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h1F || irq5 !== 1'b1 || id5 !== 5'd4) begin n_err++; $display("FAIL n5_pend: got %h irq=%0b id=%0d want 1f/1/4", d, irq5, id5); end
    ack_pulse(5'd31); repeat (2) @(negedge clk);
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h1F || irq5 !== 1'b1 || id5 !== 5'd4) begin n_err++; $display("FAIL n5_ack31: got %h irq=%0b id=%0d want 1f/1/4", d, irq5, id5); end
    ack_pulse(5'd4); repeat (2) @(negedge clk);
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h0F || id5 !== 5'd3) begin n_err++; $display("FAIL n5_ack4: got %h id=%0d want 0f/3", d, id5); end
    tgt5 = 0;
  endtask

  task automatic test_random();
    int ph; logic [2:0] o;
    ph = 0; o = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++; if ({irq, irq_id, evt} !== {m_irq, m_id, m_evt}) begin n_err++; $display("FAIL rand_out c=%0d: got %0b/%0d/%0b want %0b/%0d/%0b", c, irq, irq_id, evt, m_irq, m_id, m_evt); end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) src = src ^ (32'h1 << $urandom_range(0, 31));
      ack = ($urandom_range(0, 5) == 0);
      ack_id = $urandom_range(0, 1) ? m_id : 5'($urandom_range(0, 31));
      case (ph)
        0: if ($urandom_range(0, 1) == 1) begin
             o = 3'($urandom_range(0, 7));
             psel = 1; penable = 0; pwrite = 1'($urandom_range(0, 1));
             paddr = {7'b0, o, 2'b0};
             pwdata = (o >= 3'd3) ? ($urandom & $urandom) : $urandom;
             ph = 1;
           end
        1: begin
             penable = 1; ph = 2; #1;
             n_cmp++; if (pslverr_m !== (o >= 3'd6)) begin n_err++; $display("FAIL rand_err off=%0d: got %0b want %0b", o, pslverr_m, (o >= 3'd6)); end
             if (!pwrite) begin
               n_cmp++; if (prdata_m !== m_read(o)) begin n_err++; $display("FAIL rand_read off=%0d: got %h want %h", o, prdata_m, m_read(o)); end
             end
           end
        default: begin psel = 0; penable = 0; pwrite = 0; ph = 0; end
      endcase
    end
    @(negedge clk); psel = 0; penable = 0; ack = 0; rst = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_level();
    test_edge();
    test_set_wins();
    test_pend_set();
    test_n5();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
